// File: rtl/dram_pkg.sv
// Shared types and limits for the multi-port DRAM array model.
package dram_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      REFRESH = 2'd2
   } state_e;

   localparam int MAX_PORTS    = 4;
   localparam int MAX_READ_LAT = 4;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Array state machine and refresh timer: counts enabled ACTIVE cycles and
// holds the array in REFRESH for a fixed window at terminal count.
module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int INTERVAL = 256,
   parameter int CYCLES   = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en_i,
   output state_e state_o,
   output logic   refresh_busy_o
);

   localparam int CW = cnt_w(INTERVAL);
   localparam int BW = cnt_w(CYCLES);
   localparam bit REF_EN = (INTERVAL > 0);
   localparam logic [CW-1:0] TERM = CW'((INTERVAL > 0) ? INTERVAL - 1 : 0);
   localparam logic [BW-1:0] BTERM = BW'(CYCLES - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // The interval count survives IDLE so a disable does not postpone refresh.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      if (!en_i) begin
         state_d = IDLE;
         bcnt_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = ACTIVE;
            ACTIVE: begin
               if (REF_EN && cnt_q == TERM) begin
                  state_d = REFRESH;
                  cnt_d   = '0;
                  bcnt_d  = '0;
               end else if (REF_EN) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            REFRESH: begin
               if (bcnt_q == BTERM) begin
                  state_d = ACTIVE;
                  bcnt_d  = '0;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign state_o        = state_q;
   assign refresh_busy_o = (state_q == REFRESH);

endmodule

// File: rtl/dram_mp_array.sv
// Multi-port DRAM array: shared ready, read-first registered read pipe,
// lowest-port-wins write arbitration and out-of-bounds flagging.
module dram_mp_array
   import dram_pkg::*;
#(
   parameter int DATA_W           = 8,
   parameter int ADDR_W           = 6,
   parameter int DEPTH            = 64,
   parameter int NUM_PORTS        = 2,
   parameter int READ_LAT         = 1,
   parameter int REFRESH_INTERVAL = 256,
   parameter int REFRESH_CYCLES   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic [NUM_PORTS-1:0]                 req,
   input  logic [NUM_PORTS-1:0]                 wr,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     add,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0]     data_in,
   output logic [NUM_PORTS-1:0]                 ready,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]     data_out,
   output logic [NUM_PORTS-1:0]                 rvalid,
   output logic                                 refreshing,
   output logic                                 err_coll,
   output logic                                 err_oob
);

   state_e state;
   logic   active;

   dram_refresh_timer #(
      .INTERVAL (REFRESH_INTERVAL),
      .CYCLES   (REFRESH_CYCLES)
   ) u_timer (
      .clk            (clk),
      .rst            (rst),
      .en_i           (en),
      .state_o        (state),
      .refresh_busy_o (refreshing)
   );

   assign active = (state == ACTIVE) & en;
   assign ready  = {NUM_PORTS{active}};

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [NUM_PORTS-1:0]             acc, inb, wr_win, rd_acc;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
   logic                             coll, oob;

   // Reads sample the array before this edge's writes land (read-first).
   always_comb begin
      acc     = '0;
      inb     = '0;
      wr_win  = '0;
      rd_acc  = '0;
      rd_data = '0;
      coll    = 1'b0;
      oob     = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         acc[i]    = req[i] & active;
         inb[i]    = (int'(add[i]) < DEPTH);
         oob       = oob | (acc[i] & ~inb[i]);
         rd_acc[i] = acc[i] & wr[i];
         if (rd_acc[i] && inb[i]) rd_data[i] = mem_q[add[i]];
         wr_win[i] = acc[i] & ~wr[i] & inb[i];
         for (int j = 0; j < i; j++) begin
            if (acc[j] && !wr[j] && acc[i] && !wr[i] && add[j] == add[i]) begin
               coll      = 1'b1;
               wr_win[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++)
         if (wr_win[i]) mem_q[add[i]] <= data_in[i];
   end

   logic [NUM_PORTS-1:0][READ_LAT-1:0]             pv_q, pv_d;
   logic [NUM_PORTS-1:0][READ_LAT-1:0][DATA_W-1:0] pd_q, pd_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0]               dout_q, dout_d;
   logic                                           coll_q, oob_q;

   always_comb begin
      pv_d   = '0;
      pd_d   = '0;
      dout_d = dout_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int k = 0; k < READ_LAT; k++) begin
            if (k == 0) begin
               pv_d[i][k] = rd_acc[i];
               pd_d[i][k] = rd_data[i];
            end else begin
               pv_d[i][k] = pv_q[i][k-1];
               pd_d[i][k] = pd_q[i][k-1];
            end
         end
         if (pv_d[i][READ_LAT-1]) dout_d[i] = pd_d[i][READ_LAT-1];
      end
      if (!en) begin
         pv_d   = '0;
         dout_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q   <= '0;
         pd_q   <= '0;
         dout_q <= '0;
         coll_q <= 1'b0;
         oob_q  <= 1'b0;
      end else begin
         pv_q   <= pv_d;
         pd_q   <= pd_d;
         dout_q <= dout_d;
         coll_q <= coll;
         oob_q  <= oob;
      end
   end

   always_comb begin
      rvalid = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         rvalid[i] = pv_q[i][READ_LAT-1];
   end

   assign data_out = dout_q;
   assign err_coll = coll_q;
   assign err_oob  = oob_q;

endmodule

// File: tb/tb_dram_mp_array.sv
// Randomised bench for dram_mp_array against a transaction-level model.
module tb_dram_mp_array;

   localparam int DW  = 8;
   localparam int AW  = 6;
   localparam int DEP = 48;
   localparam int NP  = 2;
   localparam int RL  = 2;
   localparam int RI  = 16;
   localparam int RC  = 4;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     en;
   logic [NP-1:0]            req, wr;
   logic [NP-1:0][AW-1:0]    add;
   logic [NP-1:0][DW-1:0]    din;
   logic [NP-1:0]            ready;
   logic [NP-1:0][DW-1:0]    data_out;
   logic [NP-1:0]            rvalid;
   logic                     refreshing, err_coll, err_oob;

   dram_mp_array #(
      .DATA_W           (DW),
      .ADDR_W           (AW),
      .DEPTH            (DEP),
      .NUM_PORTS        (NP),
      .READ_LAT         (RL),
      .REFRESH_INTERVAL (RI),
      .REFRESH_CYCLES   (RC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req        (req),
      .wr         (wr),
      .add        (add),
      .data_in    (din),
      .ready      (ready),
      .data_out   (data_out),
      .rvalid     (rvalid),
      .refreshing (refreshing),
      .err_coll   (err_coll),
      .err_oob    (err_oob)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: array contents, pending reads by due edge, mode.
   typedef struct {
      int          port;
      int          due;
      logic [DW-1:0] d;
      bit          k;
   } rd_t;

   rd_t           rq[$];
   logic [DW-1:0] mmem[64];
   bit            mknown[64];
   int            m_st;
   int            m_act;
   int            m_ref;
   int            ecnt;
   logic [DW-1:0] e_dout[NP];
   bit            e_dk[NP];
   bit            e_rv[NP];
   bit            e_coll, e_oob;
   bit            rdy_seen, ref_seen;
   int            rv1_cnt;

   task automatic model_reset();
      m_st  = 0;
      m_act = 0;
      m_ref = 0;
      rq.delete();
      e_coll = 0;
      e_oob  = 0;
      for (int p = 0; p < NP; p++) begin
         e_dout[p] = '0;
         e_dk[p]   = 1;
         e_rv[p]   = 0;
      end
   endtask

   task automatic model_edge();
      bit rdy;
      bit dup;
      int a;
      rdy    = (m_st == 1) && en;
      e_coll = 0;
      e_oob  = 0;
      for (int p = 0; p < NP; p++) e_rv[p] = 0;
      if (!en) begin
         m_st = 0;
         rq.delete();
         for (int p = 0; p < NP; p++) begin
            e_dout[p] = '0;
            e_dk[p]   = 1;
         end
      end else begin
         if (rdy) begin
            for (int p = 0; p < NP; p++) begin
               if (req[p] && wr[p]) begin
                  a = int'(add[p]);
                  if (a >= DEP) begin
                     e_oob = 1;
                     rq.push_back('{p, ecnt + RL - 1, '0, 1'b1});
                  end else begin
                     rq.push_back('{p, ecnt + RL - 1, mmem[a], mknown[a]});
                  end
               end
            end
            for (int p = 0; p < NP; p++) begin
               if (req[p] && !wr[p]) begin
                  a   = int'(add[p]);
                  dup = 0;
                  for (int q = 0; q < p; q++)
                     if (req[q] && !wr[q] && add[q] == add[p]) dup = 1;
                  if (a >= DEP) e_oob = 1;
                  if (dup) e_coll = 1;
                  else if (a < DEP) begin
                     mmem[a]   = din[p];
                     mknown[a] = 1;
                  end
               end
            end
         end
         if (m_st == 0) m_st = 1;
         else if (m_st == 1) begin
            m_act++;
            if (m_act == RI) begin
               m_st  = 2;
               m_act = 0;
               m_ref = 0;
            end
         end else begin
            m_ref++;
            if (m_ref == RC) m_st = 1;
         end
      end
      for (int i = rq.size() - 1; i >= 0; i--) begin
         if (rq[i].due == ecnt) begin
            e_rv[rq[i].port]   = 1;
            e_dout[rq[i].port] = rq[i].d;
            e_dk[rq[i].port]   = rq[i].k;
            rq.delete(i);
         end
      end
      ecnt++;
   endtask

   task automatic cycle();
      #1;
      rdy_seen = ready[0];
      ref_seen = refreshing;
      chk("ready", 32'(ready), 32'({NP{(m_st == 1) && en}}));
      model_edge();
      @(posedge clk);
      #1;
      if (rvalid[1]) rv1_cnt++;
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("rvalid%0d", p), 32'(rvalid[p]), 32'(e_rv[p]));
         if (e_dk[p])
            chk($sformatf("dout%0d", p), 32'(data_out[p]), 32'(e_dout[p]));
      end
      chk("err_coll", 32'(err_coll), 32'(e_coll));
      chk("err_oob", 32'(err_oob), 32'(e_oob));
      chk("refreshing", 32'(refreshing), 32'(m_st == 2));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      chk("rst_errs", {30'd0, err_coll, err_oob}, 32'd0);
      chk("rst_refr", 32'(refreshing), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      model_reset();
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_rdy();
      int n;
      n   = 0;
      req = '0;
      while (!((m_st == 1) && en) && n < 50) begin
         cycle();
         n++;
      end
      if (n >= 50) chk("wait_rdy_timeout", 32'd0, 32'd1);
   endtask

   task automatic rd(input int p, input int a);
      wait_rdy();
      req      = '0;
      req[p]   = 1'b1;
      wr[p]    = 1'b1;
      add[p]   = AW'(a);
      cycle();
      req = '0;
   endtask

   task automatic wrt(input int p, input int a, input logic [DW-1:0] d);
      wait_rdy();
      req      = '0;
      req[p]   = 1'b1;
      wr[p]    = 1'b0;
      add[p]   = AW'(a);
      din[p]   = d;
      cycle();
      req = '0;
   endtask

   bit hist[32];
   bit rhist[32];
   int s;

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      req = '0;
      wr  = '0;
      add = '0;
      din = '0;
      ecnt = 0;
      rv1_cnt = 0;
      for (int i = 0; i < 64; i++) mknown[i] = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Test 1: ready stays low until enabled
      repeat (3) cycle();
      en = 1'b1;

      // Test 2: write then read on the other port
      wrt(0, 5, 8'hA5);
      rd(1, 5);
      chk("t2_early", 32'(rvalid[1]), 32'd0);
      cycle();
      chk("t2_rv", 32'(rvalid[1]), 32'd1);
      chk("t2_data", 32'(data_out[1]), 32'hA5);

      // Test 3: same-address write collision
      wait_rdy();
      req = 2'b11;
      wr  = 2'b00;
      add[0] = 6'd9;
      add[1] = 6'd9;
      din[0] = 8'h11;
      din[1] = 8'h22;
      cycle();
      chk("t3_coll", 32'(err_coll), 32'd1);
      req = '0;
      cycle();
      chk("t3_coll_pulse", 32'(err_coll), 32'd0);
      rd(0, 9);
      cycle();
      chk("t3_mem", 32'(data_out[0]), 32'h11);

      // Test 4: read-first on same-cycle read/write
      wrt(0, 3, 8'h00);
      wait_rdy();
      req = 2'b11;
      wr  = 2'b10;
      add[0] = 6'd3;
      add[1] = 6'd3;
      din[0] = 8'h7E;
      cycle();
      req = '0;
      cycle();
      chk("t4_old_rv", 32'(rvalid[1]), 32'd1);
      chk("t4_old", 32'(data_out[1]), 32'h00);
      rd(1, 3);
      cycle();
      chk("t4_new", 32'(data_out[1]), 32'h7E);

      // Test 6: out-of-bounds read, then disable clears data_out
      rd(0, 50);
      chk("t6_oob", 32'(err_oob), 32'd1);
      cycle();
      chk("t6_rv", 32'(rvalid[0]), 32'd1);
      chk("t6_zero", 32'(data_out[0]), 32'd0);
      rd(0, 5);
      cycle();
      chk("t6_pre", 32'(data_out[0]), 32'hA5);
      en = 1'b0;
      cycle();
      chk("t6_flush", 32'(data_out[0]), 32'd0);
      en = 1'b1;

      // Test 5: refresh window under continuous reads
      do_reset();
      rv1_cnt = 0;
      req = 2'b10;
      wr  = 2'b10;
      for (int k = 0; k < 30; k++) begin
         add[1] = AW'($urandom_range(0, DEP - 1));
         cycle();
         hist[k]  = rdy_seen;
         rhist[k] = ref_seen;
      end
      req = '0;
      repeat (RL + 2) cycle();
      s = 0;
      for (int k = 1; k <= 16; k++) s += int'(hist[k]);
      chk("t5_run", 32'(s), 32'd16);
      s = 0;
      for (int k = 17; k <= 20; k++) s += int'(hist[k]);
      chk("t5_gap", 32'(s), 32'd0);
      s = 0;
      for (int k = 17; k <= 20; k++) s += int'(rhist[k]);
      chk("t5_refr", 32'(s), 32'd4);
      chk("t5_resume", 32'(hist[21]), 32'd1);
      chk("t5_reads", 32'(rv1_cnt), 32'd25);

      // Randomised traffic with a mid-stream reset
      for (int n = 0; n < 800; n++) begin
         en  = ($urandom_range(0, 99) < 97);
         req = NP'($urandom);
         wr  = NP'($urandom);
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 3) == 0) add[p] = AW'($urandom_range(0, 63));
            else add[p] = AW'($urandom_range(0, 7));
            din[p] = DW'($urandom);
         end
         if (n == 400) do_reset();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
